// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// pending scoreboard and a sequential clear engine that zeroes every register
// after reset before reporting ready.
module regfile_mp_sb #(
   parameter  int XLEN   = 64,
   parameter  int NREGS  = 32,
   parameter  int NRD    = 2,
   parameter  int NWR    = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic [NRD*AW-1:0]   ra,
   output logic [NRD*XLEN-1:0] rd,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_addr,
   output logic [NREGS-1:0]    pending,
   output logic                ready
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // One bit wider than an address so NREGS itself is representable.
   localparam logic [AW:0]   NREGS_EXT = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST_REG  = AW'(NREGS - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    clr_cnt, clr_cnt_nxt;
   logic [NREGS-1:0] pending_nxt;
   logic [NWR-1:0]   wr_ok;
   logic             run;
   logic [XLEN-1:0]  mem [NREGS];

   // Register 0 and addresses beyond the last register are never stored or read.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < NREGS_EXT);
   endfunction

   // Architectural writes, reads and issues only take effect once cleared and out of reset.
   assign run   = (state == RUN) && !rst;
   assign ready = (state == RUN);

   // Qualify each write port: running, enabled and aimed at a real register.
   always_comb begin
      // NOTE: every combinational output gets a default before any condition,
      // otherwise an unassigned path would infer a latch.
      wr_ok = '0;
      for (int k = 0; k < NWR; k++) begin
         wr_ok[k] = run && we[k] && addr_ok(wa[k*AW +: AW]);
      end
   end

   // Next state: clear-counter sweep in INIT, scoreboard update in RUN.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      pending_nxt = pending;
      case (state)
         INIT: begin
            pending_nxt = '0;
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == LAST_REG) begin
               state_nxt   = RUN;
               clr_cnt_nxt = '0;
            end
         end
         RUN: begin
            // Writeback clears first so a same-cycle issue to that register wins.
            for (int k = 0; k < NWR; k++) begin
               if (wr_ok[k]) pending_nxt[wa[k*AW +: AW]] = 1'b0;
            end
            if (iss_valid && addr_ok(iss_addr)) pending_nxt[iss_addr] = 1'b1;
            pending_nxt[0] = 1'b0;
         end
         default: state_nxt = INIT;
      endcase
   end

   // State, clear counter and scoreboard registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state   <= INIT;
         clr_cnt <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         pending <= pending_nxt;
      end
   end

   // Storage array: zero-fill during INIT, port writes in RUN (highest port last, so it wins).
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the INIT sweep writes every entry before
      // ready rises, which keeps it a plain RAM without per-bit reset logic.
      if (state == INIT) begin
         mem[clr_cnt] <= '0;
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (wr_ok[k]) mem[wa[k*AW +: AW]] <= wd[k*XLEN +: XLEN];
         end
      end
   end

   // Combinational read ports with optional same-cycle forwarding from write ports.
   always_comb begin
      rd = '0;
      for (int j = 0; j < NRD; j++) begin
         if (run && addr_ok(ra[j*AW +: AW])) begin
            rd[j*XLEN +: XLEN] = mem[ra[j*AW +: AW]];
            if (BYPASS != 0) begin
               for (int k = 0; k < NWR; k++) begin
                  if (wr_ok[k] && (wa[k*AW +: AW] == ra[j*AW +: AW])) begin
                     rd[j*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a bypassing and a non-bypassing
// 32-entry instance share stimulus, plus a 24-entry, 4-read/3-write instance.
module tb_regfile_mp_sb;

   localparam int XLEN = 64;
   localparam int AW   = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Shared stimulus for the two 32-register instances
   logic [1:0]        we;
   logic [2*AW-1:0]   wa;
   logic [2*XLEN-1:0] wd;
   logic [2*AW-1:0]   ra;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic [2*XLEN-1:0] rd_a, rd_b;
   logic [31:0]       pend_a, pend_b;
   logic              ready_a, ready_b;

   // 24-register, 4-read, 3-write instance
   logic [2:0]        we_c;
   logic [3*AW-1:0]   wa_c;
   logic [3*XLEN-1:0] wd_c;
   logic [4*AW-1:0]   ra_c;
   logic [4*XLEN-1:0] rd_c;
   logic              iss_valid_c;
   logic [AW-1:0]     iss_addr_c;
   logic [23:0]       pend_c;
   logic              ready_c;

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .pending(pend_a), .ready(ready_a)
   );

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .pending(pend_b), .ready(ready_b)
   );

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(24), .NRD(4), .NWR(3), .BYPASS(1)) dut_c (
      .clk(clk), .rst(rst), .we(we_c), .wa(wa_c), .wd(wd_c), .ra(ra_c), .rd(rd_c),
      .iss_valid(iss_valid_c), .iss_addr(iss_addr_c), .pending(pend_c), .ready(ready_c)
   );

   // Scoreboard: expectations queued at stimulus time, observations queued at sample time
   typedef struct {
      string       name;
      logic [63:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   logic [63:0] obs_q[$];
   int          errors = 0;
   int          checks = 0;

   // Reference model of the 32-register instances
   logic [63:0] ref_mem [32];
   logic [31:0] ref_pend;

   task automatic expect_val(input string n, input logic [63:0] v);
      sb_q.push_back('{name: n, exp: v});
   endtask

   task automatic idle();
      we = '0; wa = '0; wd = '0; ra = '0; iss_valid = 1'b0; iss_addr = '0;
      we_c = '0; wa_c = '0; wd_c = '0; ra_c = '0; iss_valid_c = 1'b0; iss_addr_c = '0;
   endtask

   task automatic wr_a(input int k, input logic [AW-1:0] a, input logic [63:0] d);
      we[k] = 1'b1;
      wa[k*AW +: AW] = a;
      wd[k*XLEN +: XLEN] = d;
   endtask

   task automatic wr_c(input int k, input logic [AW-1:0] a, input logic [63:0] d);
      we_c[k] = 1'b1;
      wa_c[k*AW +: AW] = a;
      wd_c[k*XLEN +: XLEN] = d;
   endtask

   task automatic set_ra_c(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      ra_c = {a3, a2, a1, a0};
   endtask

   // Expected read value for port j of a 32-register instance under the current inputs
   function automatic logic [63:0] model_rd(input int j, input bit byp);
      logic [AW-1:0] a;
      logic [63:0]   v;
      a = ra[j*AW +: AW];
      if (a == '0) return '0;
      v = ref_mem[a];
      if (byp) begin
         for (int k = 0; k < 2; k++) begin
            if (we[k] && wa[k*AW +: AW] == a) v = wd[k*XLEN +: XLEN];
         end
      end
      return v;
   endfunction

   // Apply the current RUN-state inputs to the reference model (called once per committing edge)
   task automatic commit_a();
      for (int k = 0; k < 2; k++) begin
         if (we[k] && wa[k*AW +: AW] != '0) ref_mem[wa[k*AW +: AW]] = wd[k*XLEN +: XLEN];
      end
      for (int k = 0; k < 2; k++) begin
         if (we[k] && wa[k*AW +: AW] != '0) ref_pend[wa[k*AW +: AW]] = 1'b0;
      end
      if (iss_valid && iss_addr != '0) ref_pend[iss_addr] = 1'b1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_pend = '0;
   endtask

   // Initial reset: ready low for NREGS cycles, INIT ignores traffic, everything reads 0
   task automatic test_reset();
      sb_t e;
      logic [63:0] o;
      int n, nc, bad;
      repeat (3) @(negedge clk);
      #1;
      expect_val("ready_in_rst", 64'd0);  obs_q.push_back({63'd0, ready_a});
      expect_val("rd_in_rst", 64'd0);     obs_q.push_back(rd_a[63:0]);
      @(negedge clk);
      rst = 1'b0;
      wr_a(0, 5'd5, 64'hBAD0);
      wr_a(1, 5'd31, 64'hBAD1);
      ra = {5'd31, 5'd5};
      iss_valid = 1'b1;
      iss_addr = 5'd3;
      n = 0; nc = -1; bad = 0;
      while ((ready_a !== 1'b1 || ready_c !== 1'b1) && n < 200) begin
         #1;
         if (ready_c === 1'b1 && nc < 0) nc = n;
         if (ready_a !== 1'b1 && (rd_a !== '0 || pend_a !== '0)) bad++;
         @(negedge clk);
         n++;
      end
      idle();
      #1;
      expect_val("init_cycles_a", 64'd32);     obs_q.push_back(64'(n));
      expect_val("init_cycles_c", 64'd24);     obs_q.push_back(64'(nc));
      expect_val("init_quiet_cycles", 64'd0);  obs_q.push_back(64'(bad));
      expect_val("ready_b", 64'd1);            obs_q.push_back({63'd0, ready_b});
      expect_val("pending_after_init", 64'd0); obs_q.push_back({32'd0, pend_a});
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ra = {5'(31 - i), 5'(i)};
         #1;
         expect_val($sformatf("clear_rd0_x%0d", i), 64'd0); obs_q.push_back(rd_a[63:0]);
         expect_val($sformatf("clear_rd1_x%0d", 31 - i), 64'd0); obs_q.push_back(rd_a[127:64]);
      end
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // Same-cycle forwarding on the BYPASS=1 instance versus stored value on BYPASS=0
   task automatic test_bypass();
      sb_t e;
      logic [63:0] o;
      @(negedge clk);
      idle();
      wr_a(0, 5'd5, 64'hDEAD_BEEF);
      ra = {5'd5, 5'd5};
      #1;
      expect_val("byp_same_cycle", 64'hDEAD_BEEF);   obs_q.push_back(rd_a[63:0]);
      expect_val("byp_same_cycle_p1", 64'hDEAD_BEEF); obs_q.push_back(rd_a[127:64]);
      expect_val("nobyp_old_value", 64'd0);          obs_q.push_back(rd_b[63:0]);
      commit_a();
      @(negedge clk);
      idle();
      ra = {5'd0, 5'd5};
      #1;
      expect_val("nobyp_next_cycle", 64'hDEAD_BEEF); obs_q.push_back(rd_b[63:0]);
      expect_val("byp_stored", 64'hDEAD_BEEF);       obs_q.push_back(rd_a[63:0]);
      @(negedge clk);
      idle();
      wr_a(1, 5'd9, 64'h0123_4567_89AB_CDEF);
      ra = {5'd9, 5'd5};
      #1;
      expect_val("byp_port1_to_rd1", model_rd(1, 1'b1)); obs_q.push_back(rd_a[127:64]);
      expect_val("byp_other_port", model_rd(0, 1'b1));   obs_q.push_back(rd_a[63:0]);
      expect_val("nobyp_port1_old", model_rd(1, 1'b0));  obs_q.push_back(rd_b[127:64]);
      commit_a();
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // Same address on both write ports (highest port wins) and writes to x0
   task automatic test_conflict();
      sb_t e;
      logic [63:0] o;
      @(negedge clk);
      idle();
      wr_a(0, 5'd7, 64'h11);
      wr_a(1, 5'd7, 64'h22);
      ra = {5'd7, 5'd7};
      #1;
      expect_val("conflict_bypass_rd0", 64'h22); obs_q.push_back(rd_a[63:0]);
      expect_val("conflict_bypass_rd1", 64'h22); obs_q.push_back(rd_a[127:64]);
      commit_a();
      @(negedge clk);
      idle();
      wr_a(0, 5'd0, 64'hFFFF);
      ra = {5'd7, 5'd0};
      #1;
      expect_val("x0_no_bypass", 64'd0);          obs_q.push_back(rd_a[63:0]);
      expect_val("conflict_stored_a", 64'h22);    obs_q.push_back(rd_a[127:64]);
      expect_val("conflict_stored_b", 64'h22);    obs_q.push_back(rd_b[127:64]);
      commit_a();
      @(negedge clk);
      idle();
      ra = {5'd7, 5'd0};
      #1;
      expect_val("x0_reads_zero_a", 64'd0); obs_q.push_back(rd_a[63:0]);
      expect_val("x0_reads_zero_b", 64'd0); obs_q.push_back(rd_b[63:0]);
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // Pending bitmap: issue sets, writeback clears, set wins, x0 never pending
   task automatic test_scoreboard();
      sb_t e;
      logic [63:0] o;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         idle();
         case (s)
            0: begin iss_valid = 1'b1; iss_addr = 5'd3; end
            1: wr_a(0, 5'd3, 64'h33);
            2: begin iss_valid = 1'b1; iss_addr = 5'd3; wr_a(1, 5'd3, 64'h34); end
            3: begin iss_valid = 1'b1; iss_addr = 5'd0; end
            4: begin iss_valid = 1'b1; iss_addr = 5'd4; wr_a(0, 5'd10, 64'hA0); end
            default: begin
               iss_valid = 1'b1; iss_addr = 5'd6;
               wr_a(0, 5'd3, 64'h35); wr_a(1, 5'd4, 64'h44);
            end
         endcase
         commit_a();
         expect_val($sformatf("pending_a_step%0d", s), {32'd0, ref_pend});
         expect_val($sformatf("pending_b_step%0d", s), {32'd0, ref_pend});
         @(negedge clk);
         idle();
         #1;
         obs_q.push_back({32'd0, pend_a});
         obs_q.push_back({32'd0, pend_b});
      end
      expect_val("pending_only_x6", 64'h40); obs_q.push_back({32'd0, pend_a});
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // One-cycle reset over live contents: rd gated, ready low 32 cycles, all cleared
   task automatic test_reset_clear();
      sb_t e;
      logic [63:0] o;
      int n;
      @(negedge clk);
      idle();
      rst = 1'b1;
      ra = {5'd9, 5'd5};
      #1;
      expect_val("rd_gated_by_rst", 64'd0); obs_q.push_back(rd_a[63:0]);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      #1;
      expect_val("ready_low_after_rst", 64'd0); obs_q.push_back({63'd0, ready_a});
      expect_val("pending_cleared", 64'd0);     obs_q.push_back({32'd0, pend_a});
      n = 0;
      while (ready_a !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      expect_val("reclear_cycles", 64'd32); obs_q.push_back(64'(n));
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         ra = {5'(31 - i), 5'(i)};
         #1;
         expect_val($sformatf("reclear_rd0_x%0d", i), model_rd(0, 1'b1)); obs_q.push_back(rd_a[63:0]);
         expect_val($sformatf("reclear_rd1_x%0d", 31 - i), model_rd(1, 1'b0)); obs_q.push_back(rd_b[127:64]);
      end
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // Reset at INIT cycle 10 restarts the sweep; INIT-time writes and issues have no effect
   task automatic test_reset_mid_init();
      sb_t e;
      logic [63:0] o;
      int n;
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wr_a(0, 5'd12, 64'hAA);
      wr_a(1, 5'd20, 64'hBB);
      iss_valid = 1'b1;
      iss_addr = 5'd12;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (ready_a !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      idle();
      clear_model();
      ra = {5'd20, 5'd12};
      #1;
      expect_val("midinit_restart_cycles", 64'd32); obs_q.push_back(64'(n));
      expect_val("midinit_x12", 64'd0);             obs_q.push_back(rd_a[63:0]);
      expect_val("midinit_x20", 64'd0);             obs_q.push_back(rd_a[127:64]);
      expect_val("midinit_pending", 64'd0);         obs_q.push_back({32'd0, pend_a});
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   // 24-register instance: out-of-range addresses, 4 independent reads, 3-port conflict
   task automatic test_nonpow2();
      sb_t e;
      logic [63:0] o;
      @(negedge clk);
      idle();
      #1;
      expect_val("c_ready", 64'd1); obs_q.push_back({63'd0, ready_c});
      wr_c(0, 5'd1, 64'hA1);
      wr_c(1, 5'd12, 64'hB2);
      wr_c(2, 5'd30, 64'hC3);
      set_ra_c(5'd1, 5'd12, 5'd23, 5'd30);
      #1;
      expect_val("c_b1_rd0", 64'hA1); obs_q.push_back(rd_c[0*XLEN +: XLEN]);
      expect_val("c_b1_rd1", 64'hB2); obs_q.push_back(rd_c[1*XLEN +: XLEN]);
      expect_val("c_b1_rd2", 64'd0);  obs_q.push_back(rd_c[2*XLEN +: XLEN]);
      expect_val("c_b1_rd3_oor", 64'd0); obs_q.push_back(rd_c[3*XLEN +: XLEN]);
      @(negedge clk);
      idle();
      wr_c(0, 5'd23, 64'hD4);
      wr_c(2, 5'd24, 64'hE5);
      iss_valid_c = 1'b1;
      iss_addr_c = 5'd30;
      set_ra_c(5'd1, 5'd12, 5'd23, 5'd30);
      #1;
      expect_val("c_b2_rd0", 64'hA1); obs_q.push_back(rd_c[0*XLEN +: XLEN]);
      expect_val("c_b2_rd1", 64'hB2); obs_q.push_back(rd_c[1*XLEN +: XLEN]);
      expect_val("c_b2_rd2_byp", 64'hD4); obs_q.push_back(rd_c[2*XLEN +: XLEN]);
      expect_val("c_b2_rd3_oor", 64'd0);  obs_q.push_back(rd_c[3*XLEN +: XLEN]);
      @(negedge clk);
      idle();
      iss_valid_c = 1'b1;
      iss_addr_c = 5'd23;
      set_ra_c(5'd1, 5'd12, 5'd23, 5'd24);
      #1;
      expect_val("c_oor_issue_pending", 64'd0); obs_q.push_back({40'd0, pend_c});
      expect_val("c_b3_rd2", 64'hD4);      obs_q.push_back(rd_c[2*XLEN +: XLEN]);
      expect_val("c_b3_rd3_x24", 64'd0);   obs_q.push_back(rd_c[3*XLEN +: XLEN]);
      @(negedge clk);
      idle();
      wr_c(0, 5'd12, 64'h1);
      wr_c(1, 5'd12, 64'h2);
      wr_c(2, 5'd12, 64'h3);
      set_ra_c(5'd1, 5'd12, 5'd23, 5'd24);
      #1;
      expect_val("c_pending_x23", 64'h80_0000); obs_q.push_back({40'd0, pend_c});
      expect_val("c_conflict_byp", 64'h3);      obs_q.push_back(rd_c[1*XLEN +: XLEN]);
      @(negedge clk);
      idle();
      set_ra_c(5'd12, 5'd23, 5'd0, 5'd31);
      #1;
      expect_val("c_b5_rd0_x12", 64'h3);  obs_q.push_back(rd_c[0*XLEN +: XLEN]);
      expect_val("c_b5_rd1_x23", 64'hD4); obs_q.push_back(rd_c[1*XLEN +: XLEN]);
      expect_val("c_b5_rd2_x0", 64'd0);   obs_q.push_back(rd_c[2*XLEN +: XLEN]);
      expect_val("c_b5_rd3_x31", 64'd0);  obs_q.push_back(rd_c[3*XLEN +: XLEN]);
      while (obs_q.size() > 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, o, e.exp);
         end
      end
   endtask

   initial begin
      idle();
      rst = 1'b1;
      clear_model();
      test_reset();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_reset_clear();
      test_reset_mid_init();
      test_nonpow2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
